// File: rtl/mealy_fsm_unlocking_pkg.sv
// mealy_fsm_unlocking_pkg: password constant and counter widths shared by the unlocking FSM.
package mealy_fsm_unlocking_pkg;
    localparam int unsigned PWD_LEN      = 4;
    localparam logic [PWD_LEN-1:0] PASSWORD = 4'b1011;
    localparam int unsigned FAIL_CNT_W   = 8;
    localparam int unsigned LOCK_CNT_W   = 16;
endpackage

// File: rtl/mealy_fsm_unlocking_lockout.sv
// mealy_fsm_unlocking_lockout: counts consecutive failed attempts and holds a timed lockout.
module mealy_fsm_unlocking_lockout
    import mealy_fsm_unlocking_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_fail,
    input  logic i_pass,
    output logic o_locked
);
    logic [FAIL_CNT_W-1:0] r_fail_cnt;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic                  w_trip;

    assign w_trip   = i_fail && (r_fail_cnt == FAIL_CNT_W'(MAX_FAILS - 1));
    assign o_locked = r_lock_cnt != '0;

    // Fail count stays saturated for the whole lockout and clears as it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fail_cnt <= '0;
            r_lock_cnt <= '0;
        end else if (o_locked) begin
            r_lock_cnt <= r_lock_cnt - LOCK_CNT_W'(1);
            if (r_lock_cnt == LOCK_CNT_W'(1))
                r_fail_cnt <= '0;
        end else if (w_trip) begin
            r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
            r_lock_cnt <= LOCK_CNT_W'(LOCKOUT_CYCLES);
        end else if (i_pass) begin
            r_fail_cnt <= '0;
        end else if (i_fail) begin
            r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
        end
    end
endmodule

// File: rtl/mealy_fsm_unlocking.sv
// mealy_fsm_unlocking: Mealy detector for serial password 1011, non-overlapping.
// Define MEALY_FSM_UNLOCKING_LOCKOUT_EN to add a fail counter with timed lockout.
module mealy_fsm_unlocking
    import mealy_fsm_unlocking_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_ready,
    input  logic serial_valid,
    input  logic serial_data,
    output logic unlock,
    output logic pwd_incorrect
);
    typedef enum logic [1:0] {IDLE, S_1, S_10, S_101} state_t;

    state_t current_state, next_state;
    logic   w_accept;
    logic   w_locked;
    logic   w_exp_bit;
    logic   w_match;

`ifdef MEALY_FSM_UNLOCKING_LOCKOUT_EN
    mealy_fsm_unlocking_lockout #(
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout (
        .clk      (clk),
        .reset    (reset),
        .i_fail   (pwd_incorrect),
        .i_pass   (unlock),
        .o_locked (w_locked)
    );
`else
    assign w_locked = 1'b0;
`endif

    assign w_accept  = serial_valid & serial_ready & ~reset & ~w_locked;
    // State encoding doubles as the count of password bits already matched.
    assign w_exp_bit = PASSWORD[2'd3 - current_state];
    assign w_match   = serial_data == w_exp_bit;

    always_ff @(posedge clk) begin
        if (reset)
            current_state <= IDLE;
        else
            current_state <= next_state;
    end

    always_comb begin
        next_state    = current_state;
        unlock        = 1'b0;
        pwd_incorrect = 1'b0;
        if (w_locked) begin
            next_state = IDLE;
        end else if (w_accept) begin
            if (w_match) begin
                next_state = (current_state == S_101) ? IDLE : state_t'(current_state + 2'd1);
                unlock     = current_state == S_101;
            end else begin
                next_state    = IDLE;
                pwd_incorrect = current_state != IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mealy_fsm_unlocking.sv
// tb_mealy_fsm_unlocking: directed vectors for the 1011 unlocking FSM.
module tb_mealy_fsm_unlocking;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_1 = 2'd1, ST_10 = 2'd2, ST_101 = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_ready = 1'b0;
    logic serial_valid = 1'b0;
    logic serial_data = 1'b0;
    logic unlock, pwd_incorrect;
    int   checks = 0;
    int   errors = 0;

    mealy_fsm_unlocking dut (
        .clk           (clk),
        .reset         (reset),
        .serial_ready  (serial_ready),
        .serial_valid  (serial_valid),
        .serial_data   (serial_data),
        .unlock        (unlock),
        .pwd_incorrect (pwd_incorrect)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic d, input logic eu, input logic ei, input logic [1:0] es);
        @(negedge clk);
        serial_valid = 1'b1;
        serial_ready = 1'b1;
        serial_data  = d;
        #1;
        check({tag, "_unlock"}, 32'(unlock), 32'(eu));
        check({tag, "_incorrect"}, 32'(pwd_incorrect), 32'(ei));
        @(posedge clk);
        #1;
        check({tag, "_state"}, 32'(dut.current_state), 32'(es));
    endtask

    task automatic idle();
        @(negedge clk);
        serial_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset        = 1'b1;
        serial_valid = 1'b1;
        serial_ready = 1'b1;
        serial_data  = 1'b1;
        #1;
        check({tag, "_rst_unlock"}, 32'(unlock), 32'd0);
        check({tag, "_rst_incorrect"}, 32'(pwd_incorrect), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_state"}, 32'(dut.current_state), 32'(ST_IDLE));
        @(negedge clk);
        reset        = 1'b0;
        serial_valid = 1'b0;
    endtask

    task automatic pwd_ok(input string tag);
        send({tag, "_b0"}, 1'b1, 1'b0, 1'b0, ST_1);
        send({tag, "_b1"}, 1'b0, 1'b0, 1'b0, ST_10);
        send({tag, "_b2"}, 1'b1, 1'b0, 1'b0, ST_101);
        send({tag, "_b3"}, 1'b1, 1'b1, 1'b0, ST_IDLE);
    endtask

    initial begin
        do_reset("init");
        pwd_ok("basic");
        idle();

        send("bad_b0", 1'b1, 1'b0, 1'b0, ST_1);
        send("bad_b1", 1'b0, 1'b0, 1'b0, ST_10);
        send("bad_b2", 1'b0, 1'b0, 1'b1, ST_IDLE);
        send("bad_b3", 1'b1, 1'b0, 1'b0, ST_1);
        send("part_b1", 1'b0, 1'b0, 1'b0, ST_10);
        do_reset("mid");
        pwd_ok("after_rst");

        pwd_ok("b2b_a");
        pwd_ok("b2b_b");
        idle();

        send("lead0", 1'b0, 1'b0, 1'b0, ST_IDLE);
        pwd_ok("lead0_pwd");

        send("rdy_b0", 1'b1, 1'b0, 1'b0, ST_1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            serial_ready = 1'b0;
            serial_data  = i[0];
            #1;
            check("noready_unlock", 32'(unlock), 32'd0);
            check("noready_incorrect", 32'(pwd_incorrect), 32'd0);
            @(posedge clk);
            #1;
            check("noready_state", 32'(dut.current_state), 32'(ST_1));
        end
        send("rdy_b1", 1'b0, 1'b0, 1'b0, ST_10);
        send("rdy_b2", 1'b1, 1'b0, 1'b0, ST_101);
        do_reset("s101");
        idle();

`ifdef MEALY_FSM_UNLOCKING_LOCKOUT_EN
        for (int i = 0; i < 3; i++) begin
            send("lk_fail_a", 1'b1, 1'b0, 1'b0, ST_1);
            send("lk_fail_b", 1'b1, 1'b0, 1'b1, ST_IDLE);
        end
        for (int i = 0; i < 16; i++)
            send("lk_ignored", (i % 4) != 1, 1'b0, 1'b0, ST_IDLE);
        pwd_ok("lk_after");
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mealy_fsm_unlocking.md
MEALY_FSM_UNLOCKING -- requirements
Module: mealy_fsm_unlocking

Interface
REQ-001 Parameter MAX_FAILS, default 3, meaning consecutive incorrect attempts before lockout (used only with lockout compiled in).
REQ-002 Parameter LOCKOUT_CYCLES, default 16, meaning lockout duration in clk cycles (used only with lockout compiled in).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 serial_ready  input  1  downstream ready; a bit is accepted only when serial_valid=1 and serial_ready=1.
REQ-006 serial_valid  input  1  serial_data carries a password bit this cycle.
REQ-007 serial_data  input  1  password bit, MSB first.
REQ-008 unlock  output  1  Mealy pulse: correct 4-bit password 1011 completed this cycle.
REQ-009 pwd_incorrect  output  1  Mealy pulse: accepted bit breaks an in-progress sequence this cycle.

Function
REQ-010 States SHALL be IDLE, S_1, S_10 and S_101 (2-bit enum), held in register current_state, with next_state computed combinationally.
REQ-011 Accept = serial_valid & serial_ready & ~reset; without accept, state SHALL hold and both outputs SHALL be 0.
REQ-012 IDLE: accepted 1 -> S_1; accepted 0 -> IDLE, no output pulse.
REQ-013 S_1: accepted 0 -> S_10; accepted 1 -> IDLE with pwd_incorrect=1.
REQ-014 S_10: accepted 1 -> S_101; accepted 0 -> IDLE with pwd_incorrect=1.
REQ-015 S_101: accepted 1 -> IDLE with unlock=1; accepted 0 -> IDLE with pwd_incorrect=1.
REQ-016 Matching is non-overlapping: after any unlock or pwd_incorrect, the next password SHALL start from IDLE.
REQ-017 Outputs SHALL be combinational from current_state and the inputs (zero latency), asserted only during the accept cycle, never both 1.
REQ-018 Back-to-back accepts on consecutive cycles SHALL be processed one bit per cycle with no bubble.

Reset
REQ-019 When reset=1 at a rising edge, current_state SHALL become IDLE; reset mid-sequence SHALL discard partial progress.
REQ-020 While reset=1, unlock and pwd_incorrect SHALL be 0 regardless of the other inputs.
REQ-021 Reset SHALL clear the fail counter and lockout timer when these are present.

Configuration
REQ-022 Macro MEALY_FSM_UNLOCKING_LOCKOUT_EN compiles in the lockout feature.
REQ-023 With the macro defined, each pwd_incorrect SHALL increment a fail counter and each unlock SHALL clear it.
REQ-024 With the macro defined, reaching MAX_FAILS SHALL start a LOCKOUT_CYCLES-cycle lockout in which accepts are ignored (state IDLE, outputs 0), after which the counter SHALL be cleared.
REQ-025 With the macro undefined, no counter or timer logic SHALL exist and behaviour SHALL be exactly REQ-010..REQ-021.

Structure
REQ-026 Package mealy_fsm_unlocking_pkg SHALL hold PASSWORD = 4'b1011 and the counter width constants.
REQ-027 The state enum SHALL be declared inside the module so that the hierarchical names current_state, IDLE, S_1, S_10 and S_101 resolve from a bench.
REQ-028 Lockout counting SHALL be one sub-module, mealy_fsm_unlocking_lockout, instantiated only under the macro.

Verification
REQ-029 After reset, bits 1,0,1,1, each valid for one cycle -> states S_1, S_10, S_101, then IDLE; unlock=1 only during the 4th accept.
REQ-030 Bits 1,0,0,1 -> pwd_incorrect=1 on the 3rd accept and state IDLE; the 4th bit moves to S_1 with no pulse.
REQ-031 Bits 1,0 then reset held 2 cycles -> IDLE, outputs 0; a following 1,0,1,1 -> unlock=1 on its 4th accept.
REQ-032 Two consecutive 1011 sequences -> exactly two unlock pulses, no pwd_incorrect.
REQ-033 Bits 0,1,0,1,1 -> the 0 keeps IDLE with no pulse; unlock=1 on the final bit.
REQ-034 serial_valid=1 with serial_ready=0 for any data -> no state change, outputs 0; with the macro defined, 3 incorrect attempts -> the next 16 cycles ignore 1011.
